// File: rtl/pulse_pkg.sv
// pulse_pkg: shared FSM encoding and counter sizing for pulse_stretcher
package pulse_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, HIGH = 2'b01, LOW = 2'b10} state_t;
  function automatic int cnt_w(input int h, input int l);
    int m;
    m = (h > l) ? h : l;
    return (m > 1) ? $clog2(m) : 1;
  endfunction
endpackage

// File: rtl/pulse_timer.sv
// pulse_timer: loadable up-counter with done flag at a runtime terminal value
//   clk, rst_n : clock, async active-low reset
//   load       : restart count at 0 on the next edge
//   term       : terminal count for the current phase
//   done       : cnt == term
module pulse_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] term,
  output logic         done
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= load ? '0 : cnt + 1'b1;
  assign done = cnt == term;
endmodule

// File: rtl/pulse_stretcher.sv
// pulse_stretcher: turns single-cycle strobes into pulses with min high/low time
//   clk, rst_n : clock, async active-low reset
//   strobe     : single-cycle event request
//   clr_ovf    : clears sticky overflow (a same-cycle set wins)
//   out_level  : registered stretched pulse
//   busy       : registered, high while not IDLE
//   pending    : queued strobes (saturating)
//   overflow   : sticky, set when a strobe is dropped
module pulse_stretcher
  import pulse_pkg::*;
#(
  parameter int HIGH_CYCLES = 50000,
  parameter int LOW_CYCLES  = 50000,
  parameter int PEND_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              strobe,
  input  logic              clr_ovf,
  output logic              out_level,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);
  localparam int CW = cnt_w(HIGH_CYCLES, LOW_CYCLES);
  if (HIGH_CYCLES < 1 || LOW_CYCLES < 1 || PEND_W < 1) begin : g_bad_params
    $error("pulse_stretcher: HIGH_CYCLES, LOW_CYCLES and PEND_W must all be >= 1");
  end
  state_t        state, state_next;
  logic [CW-1:0] term;
  logic          done, load, last_low, deq, enq, full;
  assign term = (state == HIGH) ? CW'(HIGH_CYCLES - 1) : CW'(LOW_CYCLES - 1);
  // Counter restarts on every state change and is parked at 0 while idle.
  assign load = (state_next != state) || (state == IDLE);
  pulse_timer #(.W(CW)) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .term (term),
    .done (done)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_next;
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = strobe ? HIGH : IDLE;
      HIGH:    state_next = done ? LOW : HIGH;
      LOW:     state_next = !done ? LOW : (pending != '0 || strobe) ? HIGH : IDLE;
      default: state_next = IDLE;
    endcase
  end
  // A strobe on the last LOW cycle with nothing queued starts the next pulse
  // directly; any other strobe while busy goes into the pending queue.
  always_comb begin
    last_low = (state == LOW) && done;
    deq      = last_low && (pending != '0);
    enq      = strobe && (state == HIGH || state == LOW) && !(last_low && pending == '0);
    full     = &pending;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_level <= 1'b0;
      busy      <= 1'b0;
      pending   <= '0;
      overflow  <= 1'b0;
    end else begin
      out_level <= state_next == HIGH;
      busy      <= state_next != IDLE;
      pending   <= (deq && !enq) ? pending - 1'b1 : (enq && !deq && !full) ? pending + 1'b1 : pending;
      overflow  <= (enq && !deq && full) ? 1'b1 : clr_ovf ? 1'b0 : overflow;
    end
endmodule

// File: tb/tb_pulse_stretcher.sv
// tb_pulse_stretcher: table-driven scoreboard bench for pulse_stretcher
module tb_pulse_stretcher;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       strobe = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       out_level, busy, overflow;
  logic [1:0] pending;
  int         n_vec = 0;
  int         n_bad = 0;
  typedef struct {
    bit         r;
    bit         s;
    bit         c;
    logic [4:0] e;
  } vec_t;
  vec_t       tbl[$];
  logic [4:0] sb[$];

  pulse_stretcher #(.HIGH_CYCLES(3), .LOW_CYCLES(2), .PEND_W(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .strobe   (strobe),
    .clr_ovf  (clr_ovf),
    .out_level(out_level),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] ex(bit o, bit b, int p, bit v);
    logic [1:0] pw;
    pw = p[1:0];
    return {o, b, pw, v};
  endfunction

  task automatic add(bit r, bit s, bit c, bit o, bit b, int p, bit v);
    vec_t t;
    t.r = r; t.s = s; t.c = c; t.e = ex(o, b, p, v);
    tbl.push_back(t);
  endtask

  task automatic check(string nm);
    logic [4:0] got;
    logic [4:0] e;
    got = {out_level, busy, pending, overflow};
    e = sb.pop_front();
    n_vec++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL %s: lvl/busy/pend/ovf got %b expected %b", nm, got, e);
    end
  endtask

  task automatic do_reset();
    strobe = 1'b0;
    clr_ovf = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic apply(bit s, bit c, logic [4:0] e, string nm);
    strobe = s;
    clr_ovf = c;
    sb.push_back(e);
    @(negedge clk);
    check(nm);
  endtask

  initial begin
    // single strobe
    add(1, 1, 0, 1, 1, 0, 0); add(0, 0, 0, 1, 1, 0, 0); add(0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0); add(0, 0, 0, 0, 1, 0, 0); add(0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0);
    // burst of three
    add(1, 1, 0, 1, 1, 0, 0); add(0, 1, 0, 1, 1, 1, 0); add(0, 1, 0, 1, 1, 2, 0);
    add(0, 0, 0, 0, 1, 2, 0); add(0, 0, 0, 0, 1, 2, 0); add(0, 0, 0, 1, 1, 1, 0);
    add(0, 0, 0, 1, 1, 1, 0); add(0, 0, 0, 1, 1, 1, 0); add(0, 0, 0, 0, 1, 1, 0);
    add(0, 0, 0, 0, 1, 1, 0); add(0, 0, 0, 1, 1, 0, 0); add(0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0); add(0, 0, 0, 0, 1, 0, 0); add(0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0);
    // overflow then clear
    add(1, 1, 0, 1, 1, 0, 0); add(0, 1, 0, 1, 1, 1, 0); add(0, 1, 0, 1, 1, 2, 0);
    add(0, 1, 0, 0, 1, 3, 0); add(0, 1, 0, 0, 1, 3, 1); add(0, 0, 0, 1, 1, 2, 1);
    add(0, 0, 1, 1, 1, 2, 0); add(0, 0, 0, 1, 1, 2, 0);
    // strobe on last LOW cycle chains without an IDLE gap
    add(1, 1, 0, 1, 1, 0, 0); add(0, 0, 0, 1, 1, 0, 0); add(0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0); add(0, 0, 0, 0, 1, 0, 0); add(0, 1, 0, 1, 1, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0); add(0, 0, 0, 1, 1, 0, 0); add(0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0); add(0, 0, 0, 0, 0, 0, 0);
    // set beats clear with pending full
    add(1, 1, 0, 1, 1, 0, 0); add(0, 1, 0, 1, 1, 1, 0); add(0, 1, 0, 1, 1, 2, 0);
    add(0, 1, 0, 0, 1, 3, 0); add(0, 1, 1, 0, 1, 3, 1); add(0, 0, 0, 1, 1, 2, 1);

    do_reset();
    sb.push_back(5'b0);
    check("reset_state");
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].r) do_reset();
      apply(tbl[i].s, tbl[i].c, tbl[i].e, $sformatf("vec%0d", i));
    end

    // asynchronous reset in the middle of a pulse with overflow set
    do_reset();
    apply(1, 0, ex(1, 1, 0, 0), "pre_rst0");
    apply(1, 0, ex(1, 1, 1, 0), "pre_rst1");
    apply(1, 0, ex(1, 1, 2, 0), "pre_rst2");
    apply(1, 0, ex(0, 1, 3, 0), "pre_rst3");
    apply(1, 0, ex(0, 1, 3, 1), "pre_rst4");
    apply(0, 0, ex(1, 1, 2, 1), "pre_rst5");
    #2;
    rst_n = 1'b0;
    strobe = 1'b1;
    #1;
    sb.push_back(5'b0);
    check("rst_async");
    @(negedge clk);
    sb.push_back(5'b0);
    check("rst_hold_strobe");
    rst_n = 1'b1;
    apply(0, 0, ex(0, 0, 0, 0), "post_rst0");
    apply(0, 0, ex(0, 0, 0, 0), "post_rst1");
    apply(0, 0, ex(0, 0, 0, 0), "post_rst2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
